// File: rtl/pipe_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_addsub_pkg
// Description : Shared types and helpers for the pipelined adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_addsub_pkg;

    // Widest operand the saturation helper can describe
    localparam int SAT_MAX_W = 64;

    // Operation select carried on the sub input
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Width of one pipeline chunk
    function automatic int chunk_width(input int n, input int stages);
        return n / stages;
    endfunction

    // Largest positive (sign=0) or most negative (sign=1) n-bit signed value,
    // right-aligned in a SAT_MAX_W-bit word; callers cast down to n bits.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int n);
        logic [SAT_MAX_W-1:0] msb;
        msb = {{(SAT_MAX_W-1){1'b0}}, 1'b1} << (n - 1);
        return sign ? msb : (msb - {{(SAT_MAX_W-1){1'b0}}, 1'b1});
    endfunction

endpackage : pipe_addsub_pkg
`default_nettype wire

// File: rtl/pipe_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_addsub_if
// Description : Operand/result handshake bundle of pipe_addsub.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_addsub_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    // Producer/consumer side
    modport master (
        output in_valid, a, b, cin, sub, sat_en, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Arithmetic block side
    modport slave (
        input  in_valid, a, b, cin, sub, sat_en, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface : pipe_addsub_if
`default_nettype wire

// File: rtl/addsub_stage.sv
`default_nettype none
// ============================================================================
// Module      : addsub_stage
// Description : W-bit ripple-carry chunk adder built from full_adder cells.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_stage #(
    parameter int W = 4
) (
    input  wire logic [W-1:0] a,
    input  wire logic [W-1:0] b,
    input  wire logic         ci,
    output logic      [W-1:0] s,
    output logic              co
);
    logic [W:0] w_carry;

    assign w_carry[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_carry[i]),
            .s  (s[i]),
            .co (w_carry[i+1])
        );
    end

    assign co = w_carry[W];
endmodule : addsub_stage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic ci,
    output logic      s,
    output logic      co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule : full_adder
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipe_addsub
// Description : Pipelined N-bit adder/subtractor, one W-bit chunk per stage,
//               valid/ready backpressure, signed overflow and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    pipe_addsub_if.slave  bus
);
    localparam int W = chunk_width(N, STAGES);

    if ((N < 2) || ((N % STAGES) != 0)) begin : g_param_check
        $error("pipe_addsub: N must be >= 2 and a multiple of STAGES");
    end

    // Per-stage inputs: index 0 is the conditioned operand beat, index k>0
    // is what stage k-1 registered. The sub flag is folded into bb and the
    // carry at entry, so only sat_en travels down the pipe.
    logic [N-1:0] w_a   [STAGES];
    logic [N-1:0] w_bb  [STAGES];
    logic [N-1:0] w_s   [STAGES];
    logic         w_c   [STAGES];
    logic         w_sat [STAGES];
    logic [STAGES-1:0] w_v;
    logic [STAGES:0]   w_adv;
    op_e               w_op;

    assign w_op     = op_e'(bus.sub);
    assign w_a[0]   = bus.a;
    assign w_bb[0]  = (w_op == OP_SUB) ? ~bus.b   : bus.b;
    assign w_c[0]   = (w_op == OP_SUB) ? ~bus.cin : bus.cin;
    assign w_s[0]   = '0;
    assign w_sat[0] = bus.sat_en;
    assign w_v[0]   = bus.in_valid;

    // Ready ripples backwards from the consumer; no skid buffer
    assign w_adv[STAGES] = bus.out_ready;
    assign bus.in_ready  = w_adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] w_chunk;
        logic         w_co;
        logic [N-1:0] w_sum_next;
        logic         r_valid;

        addsub_stage #(.W(W)) u_stage (
            .a  (w_a[k][k*W +: W]),
            .b  (w_bb[k][k*W +: W]),
            .ci (w_c[k]),
            .s  (w_chunk),
            .co (w_co)
        );

        // An empty stage always accepts, which collapses bubbles under stall
        assign w_adv[k] = !r_valid || w_adv[k+1];

        // Splice this stage's chunk into the running partial sum
        always_comb begin
            w_sum_next              = w_s[k];
            w_sum_next[k*W +: W]    = w_chunk;
        end

        // Stage occupancy: loads upstream valid whenever the stage advances
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
            end else if (w_adv[k]) begin
                r_valid <= w_v[k];
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [N-1:0] r_a;
            logic [N-1:0] r_bb;
            logic [N-1:0] r_s;
            logic         r_c;
            logic         r_sat;

            // Skew and partial-result registers, captured on a real transfer
            always_ff @(posedge clk) begin
                if (w_adv[k] && w_v[k]) begin
                    r_a   <= w_a[k];
                    r_bb  <= w_bb[k];
                    r_s   <= w_sum_next;
                    r_c   <= w_co;
                    r_sat <= w_sat[k];
                end
            end

            assign w_a[k+1]   = r_a;
            assign w_bb[k+1]  = r_bb;
            assign w_s[k+1]   = r_s;
            assign w_c[k+1]   = r_c;
            assign w_sat[k+1] = r_sat;
            assign w_v[k+1]   = r_valid;
        end else begin : g_last
            logic         w_ovf;
            logic [N-1:0] w_sat_val;
            logic [N-1:0] r_sum;
            logic         r_cout;
            logic         r_ovf;

            // Same-sign operands giving a different-sign raw result overflow
            assign w_ovf     = (w_a[k][N-1] == w_bb[k][N-1]) &&
                               (w_sum_next[N-1] != w_a[k][N-1]);
            assign w_sat_val = N'(sat_value(w_a[k][N-1], N));

            // Result registers; held while the consumer stalls
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                end else if (w_adv[k] && w_v[k]) begin
                    r_sum  <= (w_sat[k] && w_ovf) ? w_sat_val : w_sum_next;
                    r_cout <= w_co;
                    r_ovf  <= w_ovf;
                end
            end

            assign bus.out_valid = r_valid;
            assign bus.sum       = r_sum;
            assign bus.cout      = r_cout;
            assign bus.ovf       = r_ovf;
        end
    end
endmodule : pipe_addsub
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_addsub
// Description : Self-checking bench for pipe_addsub (N=16, STAGES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;
    localparam int N      = 16;
    localparam int STAGES = 4;

    logic clk;
    logic rst_n;

    pipe_addsub_if #(.N(N)) bus ();

    pipe_addsub #(.N(N), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_in  = 0;
    int n_out = 0;
    logic [17:0] q[$];
    bit          acc_now;
    bit          got_out;
    int          acc_cyc;
    int          got_cyc;
    logic [17:0] got_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: true integer result, range check for overflow, clamp on sat
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub, input logic sat);
        int ua, ub, sa, sb, t, s;
        logic [15:0] r;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            t  = ua - ub - int'(cin);
            s  = sa - sb - int'(cin);
            co = (ua >= ub + int'(cin));
        end else begin
            t  = ua + ub + int'(cin);
            s  = sa + sb + int'(cin);
            co = (t > 65535);
        end
        r  = 16'(t);
        ov = (s > 32767) || (s < -32768);
        if (sat && ov) r = (s > 0) ? 16'h7FFF : 16'h8000;
        return {r, co, ov};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: observe/score at negedge, let the edge happen, return at +1
    task automatic tick();
        @(negedge clk);
        acc_now = 1'b0;
        if (bus.out_valid === 1'b1) begin
            chk("out_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("out_data", 32'({bus.sum, bus.cout, bus.ovf}), 32'(q[0]));
                if (bus.out_ready) begin
                    got_out = 1'b1;
                    got_cyc = cyc;
                    got_val = {bus.sum, bus.cout, bus.ovf};
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, bus.sat_en));
            acc_now = 1'b1;
            acc_cyc = cyc;
            n_in++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic sat,
                          input logic [15:0] es, input logic ec, input logic eo);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.sat_en = sat;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        got_out = 1'b0;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !got_out; i++) tick();
        chk({tag, "_seen"},    32'(got_out), 32'd1);
        chk({tag, "_latency"}, 32'(got_cyc - acc_cyc), 32'(STAGES));
        chk({tag, "_sum"},     32'(got_val[17:2]), 32'(es));
        chk({tag, "_cout"},    32'(got_val[1]), 32'(ec));
        chk({tag, "_ovf"},     32'(got_val[0]), 32'(eo));
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int accepted, beat, base_in, base_out, cnt, guard;

        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.sat_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed arithmetic
        single("add",      16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        single("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0);
        single("ovf_nsat", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single("ovf_sat",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        single("sub_sat",  16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
        single("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure: 8 beats, consumer stalled for 6 cycles
        base_out = n_out;
        accepted = 0;
        beat = 0;
        bus.cin = 1'b0; bus.sub = 1'b0; bus.sat_en = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 16'(beat); bus.b = 16'(beat);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acc_now) begin
                accepted++;
                beat++;
                bus.a = 16'(beat); bus.b = 16'(beat);
            end
        end
        chk("bp_accepts",  32'(accepted), 32'd4);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_no_out",   32'(n_out - base_out), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && beat < 8; i++) begin
            tick();
            if (acc_now) begin
                beat++;
                bus.a = 16'(beat); bus.b = 16'(beat);
            end
        end
        chk("bp_all_sent", 32'(beat), 32'd8);
        drain();
        chk("bp_out_count", 32'(n_out - base_out), 32'd8);

        // Random traffic with random valid/ready
        base_in  = n_in;
        base_out = n_out;
        cnt   = 0;
        guard = 0;
        bus.in_valid = 1'b0;
        acc_now = 1'b0;
        while (cnt < 1000 && guard < 20000) begin
            if (!bus.in_valid || acc_now) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.a      = rnd16();
                bus.b      = rnd16();
                bus.cin    = 1'($urandom);
                bus.sub    = 1'($urandom);
                bus.sat_en = 1'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc_now) cnt++;
            guard++;
        end
        chk("rand_sent", 32'(cnt), 32'd1000);
        drain();
        chk("rand_in_out", 32'(n_out - base_out), 32'(n_in - base_in));

        // Reset with three beats in flight, oldest at the output
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.sub = 1'b0; bus.cin = 1'b0; bus.sat_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.a = 16'(100 + i); bus.b = 16'h0001;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum",   32'(bus.sum),       32'd0);
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_stale", 32'(bus.out_valid), 32'd0);
        end
        single("post_rst", 16'h0102, 16'h0304, 1'b1, 1'b0, 1'b0, 16'h0407, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_pipe_addsub
`default_nettype wire

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined N-bit adder/subtractor; the next generation of the combinational ripple-carry adder.
- The N-bit operation is split into STAGES chunks of W=N/STAGES bits. Each chunk ripples in its own registered stage, and the carry is passed stage-to-stage.
- A valid/ready handshake on both sides provides full backpressure (stall without loss).
- Adds a subtract mode, signed overflow detection and optional signed saturation.
- Sits between datapath producers and consumers (accumulators, ALU back end) where a full N-bit ripple does not close timing.

Parameters:
- N, 16, operand and result width; N >= 2.
- STAGES, 4, pipeline depth = chunk count; N % STAGES == 0 (elaboration error otherwise). STAGES=1 gives a registered single-stage adder.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  1: a-b-cin; 0: a+b+cin.
- sat_en  in  1  1: signed saturation on overflow.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  result.
- cout  out  1  raw carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  out  1  signed overflow of the unsaturated result.

Behaviour:
- Operand conditioning at stage 0:
  - bb = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - Hence sub computes a + ~b + ~cin = a - b - cin mod 2^N.
- Stage k (0..STAGES-1) adds chunk k of a and bb plus the carry registered from stage k-1 (c0 for k=0). It registers:
  - the W-bit partial sum;
  - the carry out;
  - the not-yet-processed upper chunks of a and bb (skew registers);
  - the lower sums already produced;
  - sub and sat_en;
  - a stage valid bit.
- Final stage produces all outputs:
  - cout = carry out of bit N-1.
  - ovf = (a[N-1] == bb[N-1]) && (raw[N-1] != a[N-1]).
- Saturation at the final stage, when sat_en && ovf:
  - sum = a[N-1] ? {1'b1, {N-1{1'b0}}} : {1'b0, {N-1{1'b1}}}.
  - cout and ovf still report the raw values.
  - Otherwise sum = raw.
- Latency: STAGES cycles from an accepted input to out_valid, with no stalls.
- Throughput: one beat per cycle when out_ready is held at 1.
- Handshake:
  - Stage k advances when its valid is 0 or stage k+1 advances. The last stage advances on out_ready or when empty.
  - in_ready = stage-0 advance condition. It is combinational from out_ready through the chain; no skid buffer is required.
  - Transfer occurs only when valid && ready on each side.
  - out_valid and sum are stable while out_valid && !out_ready.
  - Full pipeline with out_ready=0: in_ready=0 and no beat is lost or duplicated.
  - Pipeline with bubbles: bubbles collapse while the output is stalled (a stage with valid=0 always accepts).
- Simultaneous events: when the pipeline is full and out_ready=1, an input is accepted in the same cycle the output drains.
- Wrap-around: results are modulo 2^N.
  - 0xFFFF + 0x0001 gives sum 0, cout 1, ovf 0.
- Reset (asynchronous, any time including mid-operation):
  - All stage valids are cleared and all in-flight beats are discarded.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Data registers need no reset; output-facing registers are reset to 0.

Decomposition:
- Shared package pipe_addsub_pkg:
  - localparam helper for chunk width W = N/STAGES.
  - function sat_value(sign, N) returning the max/min signed constant.
- One sub-module, addsub_stage: W-bit chunk add with carry-in/out, using the team's existing full_adder cell in a generate loop.
- The top generates STAGES instances of addsub_stage plus the skew, valid and handshake registers.

Test Plan (N=16, STAGES=4):
- Add: a=0x1234, b=0x1111, cin=0, sub=0, out_ready=1.
  - Result after 4 cycles: sum=0x2345, cout=0, ovf=0.
- Sub with borrow: a=0x0005, b=0x0007, cin=1, sub=1.
  - Result: sum=0xFFFD, cout=0, ovf=0.
- Overflow and saturation: a=0x7FFF, b=0x0001, add.
  - sat_en=0: sum=0x8000, ovf=1.
  - sat_en=1: sum=0x7FFF, ovf=1.
  - a=0x8000, b=0x0001, sub, sat_en=1: sum=0x8000, ovf=1.
- Backpressure: stream 8 beats (a=i, b=i) with out_ready=0 for 6 cycles, then 1.
  - in_ready drops after 4 accepts.
  - All 8 results (2i) emerge in order, with sum held stable while stalled.
- Throughput and random: 1000 random beats with random in_valid/out_ready.
  - Every result matches the reference model (a±b±cin, ovf, sat) in order, with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight.
  - out_valid=0 and sum=0 immediately.
  - After release, no stale beat emerges and the first new beat returns after 4 cycles.
